// File: rtl/forwarding_hazard_unit.sv
// Forwarding and hazard unit for the EX stage.
// Picks a bypass source for each EX operand (youngest matching stage wins),
// raises stall on load-use and on reads of pending multi-cycle results, and
// tracks in-flight multi-cycle writes in a small countdown scoreboard.
module forwarding_hazard_unit #(
   parameter int unsigned NUM_SRC    = 3,
   parameter int unsigned NUM_FWD    = 2,
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned PEND_DEPTH = 4,
   parameter int unsigned LAT_W      = 3,
   parameter int unsigned ZERO_REG   = 1,
   localparam int unsigned SEL_W     = $clog2(NUM_FWD + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SRC*REG_AW-1:0]   src_ex,
   input  logic [NUM_SRC-1:0]          src_vld_ex,
   input  logic [NUM_FWD*REG_AW-1:0]   dst_fwd,
   input  logic [NUM_FWD-1:0]          wb_fwd,
   input  logic [NUM_FWD-1:0]          rdy_fwd,
   input  logic                        issue_vld,
   input  logic [REG_AW-1:0]           issue_dst,
   input  logic [LAT_W-1:0]            issue_lat,
   input  logic                        flush,
   output logic [NUM_SRC*SEL_W-1:0]    src_sel,
   output logic                        forward,
   output logic                        stall,
   output logic                        pend_full,
   output logic [15:0]                 stall_cnt
);

   localparam int unsigned IDX_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

   // scoreboard state
   logic [PEND_DEPTH-1:0]             r_vld;
   logic [PEND_DEPTH-1:0][REG_AW-1:0] r_dst;
   logic [PEND_DEPTH-1:0][LAT_W-1:0]  r_cnt;
   logic                              r_pend_full;
   logic [15:0]                       r_stall_cnt;

   // combinational results
   logic [NUM_SRC*SEL_W-1:0]          w_src_sel;
   logic                              w_load_use;
   logic                              w_sb_haz;
   logic                              w_stall;
   logic                              w_free;
   logic [IDX_W-1:0]                  w_free_idx;
   logic                              w_alloc;
   logic [PEND_DEPTH-1:0]             w_vld_nxt;
   logic [PEND_DEPTH-1:0][REG_AW-1:0] w_dst_nxt;
   logic [PEND_DEPTH-1:0][LAT_W-1:0]  w_cnt_nxt;

   // per-operand bypass select, load-use and scoreboard hazard detection
   always_comb begin
      logic [REG_AW-1:0] v_src;
      logic              v_rd;
      logic              v_hit;
      w_src_sel  = '0;
      w_load_use = 1'b0;
      w_sb_haz   = 1'b0;
      v_src      = '0;
      v_rd       = 1'b0;
      v_hit      = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         v_src = src_ex[i*REG_AW +: REG_AW];
         v_rd  = src_vld_ex[i] && !((ZERO_REG != 0) && (v_src == '0));
         v_hit = 1'b0;
         for (int k = 0; k < NUM_FWD; k++) begin
            if (!v_hit && v_rd && wb_fwd[k] && (dst_fwd[k*REG_AW +: REG_AW] == v_src)) begin
               v_hit                       = 1'b1;
               w_src_sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
               if (!rdy_fwd[k]) begin
                  w_load_use = 1'b1;
               end
            end
         end
         for (int e = 0; e < PEND_DEPTH; e++) begin
            if (v_rd && r_vld[e] && (r_cnt[e] != '0) && (r_dst[e] == v_src)) begin
               w_sb_haz = 1'b1;
            end
         end
      end
   end

   // stall decision and allocation grant
   always_comb begin
      w_stall = w_load_use || w_sb_haz || (issue_vld && r_pend_full);
      w_alloc = issue_vld && !w_stall && !r_pend_full && w_free;
   end

   // lowest entry free at the start of this cycle; slots freed this cycle wait
   always_comb begin
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int e = 0; e < PEND_DEPTH; e++) begin
         if (!w_free && !r_vld[e]) begin
            w_free     = 1'b1;
            w_free_idx = IDX_W'(e);
         end
      end
   end

   // scoreboard next state: countdown, retire, allocate, flush override
   always_comb begin
      w_vld_nxt = r_vld;
      w_dst_nxt = r_dst;
      w_cnt_nxt = r_cnt;
      for (int e = 0; e < PEND_DEPTH; e++) begin
         if (r_vld[e]) begin
            if (r_cnt[e] != '0) begin
               w_cnt_nxt[e] = r_cnt[e] - LAT_W'(1);
            end else begin
               w_vld_nxt[e] = 1'b0;
            end
         end
         if (w_alloc && (IDX_W'(e) == w_free_idx)) begin
            w_vld_nxt[e] = 1'b1;
            w_dst_nxt[e] = issue_dst;
            w_cnt_nxt[e] = issue_lat;
         end
         if (flush) begin
            w_vld_nxt[e] = 1'b0;
         end
      end
   end

   // state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld       <= '0;
         r_dst       <= '0;
         r_cnt       <= '0;
         r_pend_full <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_vld       <= w_vld_nxt;
         r_dst       <= w_dst_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pend_full <= &w_vld_nxt;
         if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   // output drive
   always_comb begin
      src_sel   = w_src_sel;
      forward   = |w_src_sel;
      stall     = w_stall;
      pend_full = r_pend_full;
      stall_cnt = r_stall_cnt;
   end

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit with an expectation queue and
// an independent monitor that compares each cycle's outputs mid-cycle.
module tb_forwarding_hazard_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] src_ex = '0;
   logic [2:0]  src_vld_ex = '0;
   logic [9:0]  dst_fwd = '0;
   logic [1:0]  wb_fwd = '0;
   logic [1:0]  rdy_fwd = '0;
   logic        issue_vld = 1'b0;
   logic [4:0]  issue_dst = '0;
   logic [2:0]  issue_lat = '0;
   logic        flush = 1'b0;
   logic [5:0]  src_sel;
   logic        forward;
   logic        stall;
   logic        pend_full;
   logic [15:0] stall_cnt;

   typedef struct {
      string       nm;
      int          cyc;
      logic [5:0]  sel;
      logic        fw;
      logic        st;
      logic        pf;
      logic [15:0] sc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   done = 1'b0;

   forwarding_hazard_unit dut (
      .clk        (clk),
      .reset      (reset),
      .src_ex     (src_ex),
      .src_vld_ex (src_vld_ex),
      .dst_fwd    (dst_fwd),
      .wb_fwd     (wb_fwd),
      .rdy_fwd    (rdy_fwd),
      .issue_vld  (issue_vld),
      .issue_dst  (issue_dst),
      .issue_lat  (issue_lat),
      .flush      (flush),
      .src_sel    (src_sel),
      .forward    (forward),
      .stall      (stall),
      .pend_full  (pend_full),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input string nm, input string field, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, field, act, exp, cyc);
      end
   endtask

   // monitor: pop the expectation for this cycle and compare mid-cycle
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0 && q[0].cyc < cyc) begin
         e = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.nm, e.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
         e = q.pop_front();
         cmp(e.nm, "src_sel",   16'(src_sel),   16'(e.sel));
         cmp(e.nm, "forward",   16'(forward),   16'(e.fw));
         cmp(e.nm, "stall",     16'(stall),     16'(e.st));
         cmp(e.nm, "pend_full", 16'(pend_full), 16'(e.pf));
         cmp(e.nm, "stall_cnt", stall_cnt,      e.sc);
      end
   end

   // push the expectation for the current cycle, then advance one cycle
   task automatic step(input string nm, input logic [5:0] sel, input logic fw,
                       input logic st, input logic pf, input logic [15:0] sc);
      exp_t e;
      e.nm = nm; e.cyc = cyc; e.sel = sel; e.fw = fw; e.st = st; e.pf = pf; e.sc = sc;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      src_ex = '0; src_vld_ex = '0; dst_fwd = '0; wb_fwd = '0; rdy_fwd = '0;
      issue_vld = 1'b0; issue_dst = '0; issue_lat = '0; flush = 1'b0;
   endtask

   task automatic do_reset(input string nm);
      reset = 1'b1;
      idle();
      @(posedge clk);
      #1;
      step(nm, 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      reset = 1'b0;
   endtask

   initial begin
      // test 1: youngest stage wins, operand valid masking, wb gating
      do_reset("rst1");
      src_ex = {5'd3, 5'd2, 5'd1}; src_vld_ex = 3'b111;
      dst_fwd = {5'd1, 5'd1}; wb_fwd = 2'b11; rdy_fwd = 2'b11;
      step("t1_young", 6'b000001, 1'b1, 1'b0, 1'b0, 16'd0);
      src_ex = {5'd1, 5'd2, 5'd9}; dst_fwd = {5'd2, 5'd1};
      step("t1_mix", 6'b011000, 1'b1, 1'b0, 1'b0, 16'd0);
      src_vld_ex = 3'b001;
      step("t1_vldmask", 6'b000000, 1'b0, 1'b0, 1'b0, 16'd0);
      src_vld_ex = 3'b111; wb_fwd = 2'b01;
      step("t1_wbgate", 6'b010000, 1'b1, 1'b0, 1'b0, 16'd0);

      // test 2: load-use stall and release
      do_reset("rst2");
      src_ex = {5'd11, 5'd5, 5'd10}; src_vld_ex = 3'b111;
      dst_fwd = {5'd0, 5'd5}; wb_fwd = 2'b01; rdy_fwd = 2'b00;
      step("t2_lduse", 6'b000100, 1'b1, 1'b1, 1'b0, 16'd0);
      rdy_fwd = 2'b01;
      step("t2_ready", 6'b000100, 1'b1, 1'b0, 1'b0, 16'd1);
      dst_fwd = {5'd5, 5'd5}; wb_fwd = 2'b11; rdy_fwd = 2'b01;
      step("t2_olderignored", 6'b000100, 1'b1, 1'b0, 1'b0, 16'd1);
      wb_fwd = 2'b10;
      step("t2_wbstage", 6'b001000, 1'b1, 1'b1, 1'b0, 16'd1);
      idle();
      step("t2_idle", 6'b000000, 1'b0, 1'b0, 1'b0, 16'd2);

      // test 3: multi-cycle producer, lat 3
      do_reset("rst3");
      issue_vld = 1'b1; issue_dst = 5'd7; issue_lat = 3'd3;
      step("t3_issue", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      idle(); src_ex = {5'd0, 5'd0, 5'd7}; src_vld_ex = 3'b001;
      step("t3_cnt3", 6'd0, 1'b0, 1'b1, 1'b0, 16'd0);
      step("t3_cnt2", 6'd0, 1'b0, 1'b1, 1'b0, 16'd1);
      step("t3_cnt1", 6'd0, 1'b0, 1'b1, 1'b0, 16'd2);
      step("t3_cnt0", 6'd0, 1'b0, 1'b0, 1'b0, 16'd3);
      step("t3_gone", 6'd0, 1'b0, 1'b0, 1'b0, 16'd3);

      // test 4: fill scoreboard, full issue stalls, flush clears
      do_reset("rst4");
      issue_vld = 1'b1; issue_lat = 3'd7;
      for (int n = 0; n < 4; n++) begin
         issue_dst = 5'(8 + n);
         step("t4_fill", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      end
      issue_dst = 5'd12;
      step("t4_fullissue", 6'd0, 1'b0, 1'b1, 1'b1, 16'd0);
      issue_vld = 1'b0; flush = 1'b1;
      step("t4_flush", 6'd0, 1'b0, 1'b0, 1'b1, 16'd1);
      flush = 1'b0; src_ex = {5'd0, 5'd0, 5'd8}; src_vld_ex = 3'b001;
      step("t4_afterflush", 6'd0, 1'b0, 1'b0, 1'b0, 16'd1);

      // test 5: register zero never forwards or stalls
      do_reset("rst5");
      src_ex = '0; src_vld_ex = 3'b111; dst_fwd = '0; wb_fwd = 2'b01; rdy_fwd = 2'b00;
      step("t5_x0fwd", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      wb_fwd = 2'b00; issue_vld = 1'b1; issue_dst = 5'd0; issue_lat = 3'd3;
      step("t5_x0issue", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      issue_vld = 1'b0;
      step("t5_x0read", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);

      // test 6: asynchronous reset mid-countdown
      do_reset("rst6");
      issue_vld = 1'b1; issue_dst = 5'd7; issue_lat = 3'd7;
      step("t6_issue", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      idle(); src_ex = {5'd0, 5'd0, 5'd7}; src_vld_ex = 3'b001;
      step("t6_stall_a", 6'd0, 1'b0, 1'b1, 1'b0, 16'd0);
      step("t6_stall_b", 6'd0, 1'b0, 1'b1, 1'b0, 16'd1);
      reset = 1'b1;
      step("t6_asyncrst", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      reset = 1'b0;
      step("t6_released", 6'd0, 1'b0, 1'b0, 1'b0, 16'd0);

      idle();
      done = 1'b1;
   end

   // end of run: drain the queue with a bounded wait, then summarise
   initial begin
      int guard;
      guard = 0;
      wait (done);
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
